// File: rtl/csr_ctrl_pkg.sv
// csr_ctrl_pkg: shared CSR encodings used by csr_ctrl and its write-data ALU.
//   - csr_state_o codes seen by the CSR file
//   - machine-mode CSR addresses
//   - funct3 CSR operation codes
//   - controller FSM state type and a funct3 legality helper
package csr_ctrl_pkg;

  localparam logic [1:0] CSR_STATE_IDLE  = 2'b00;
  localparam logic [1:0] CSR_STATE_RW    = 2'b01;
  localparam logic [1:0] CSR_STATE_ECALL = 2'b10;
  localparam logic [1:0] CSR_STATE_MRET  = 2'b11;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [2:0] CSR_OP_RW  = 3'b001;
  localparam logic [2:0] CSR_OP_RS  = 3'b010;
  localparam logic [2:0] CSR_OP_RC  = 3'b011;
  localparam logic [2:0] CSR_OP_RWI = 3'b101;
  localparam logic [2:0] CSR_OP_RSI = 3'b110;
  localparam logic [2:0] CSR_OP_RCI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_TRAP = 2'b11
  } csr_fsm_e;

  // 000 and 100 are not CSR operations; every other funct3 is.
  function automatic logic is_csr_op(input logic [2:0] funct3);
    return funct3[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/csr_wdata_alu.sv
// csr_wdata_alu: combinational write-data and write-enable for a CSR op.
//   funct3_i   : CSR op code (RW/RS/RC and immediate variants)
//   rs1_idx_i  : rs1 index, doubles as zimm for the immediate variants
//   rs1_data_i : rs1 register value
//   old_i      : CSR value read in the RD cycle
//   wdata_o    : new CSR value
//   wen_o      : 0 for set/clear ops whose rs1 field is zero (no side effect)
module csr_wdata_alu
  import csr_ctrl_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rs1_idx_i,
  input  logic [63:0] rs1_data_i,
  input  logic [63:0] old_i,
  output logic [63:0] wdata_o,
  output logic        wen_o
);

  logic [63:0] src;

  always_comb begin
    src     = funct3_i[2] ? {59'd0, rs1_idx_i} : rs1_data_i;
    wdata_o = '0;
    wen_o   = 1'b0;
    case (funct3_i)
      CSR_OP_RW, CSR_OP_RWI: begin
        wdata_o = src;
        wen_o   = 1'b1;
      end
      CSR_OP_RS, CSR_OP_RSI: begin
        wdata_o = old_i | src;
        wen_o   = rs1_idx_i != 5'd0;
      end
      CSR_OP_RC, CSR_OP_RCI: begin
        wdata_o = old_i & ~src;
        wen_o   = rs1_idx_i != 5'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_ctrl.sv
// csr_ctrl: sequences CSR read-modify-write ops and ECALL/MRET traps
// against an external CSR file.
//   clk, rst_n                     : clock, synchronous active-low reset
//   in_valid_i / in_ready_o        : instruction handshake
//   funct3_i, csr_addr_i, rs1_*    : CSR op fields
//   is_ecall_i, is_mret_i, pc_i    : trap request and its PC
//   csr_state_o, csr_r*/csr_w*     : requests to the CSR file
//   csr_pc_o                       : PC handed over for trap entry
//   csr_r_data_i, csr_dnpc_i       : combinational CSR read data / trap target
//   rd_wen_o, rd_data_o            : one-cycle write-back of the old CSR value
//   redirect_valid_o/redirect_pc_o : one-cycle fetch redirect after a trap
//
// state | meaning
// IDLE  | waiting for an instruction (blocked while a redirect is out)
// RD    | read request to CSR file, capture old value
// WR    | write request (unless suppressed) and rd write-back
// TRAP  | ECALL/MRET to CSR file, capture trap target for redirect
//
// Request outputs are also qualified by rst_n so that a reset cycle landing
// on RD/WR/TRAP issues nothing.
module csr_ctrl
  import csr_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  funct3_i,
  input  logic [11:0] csr_addr_i,
  input  logic [4:0]  rs1_idx_i,
  input  logic [63:0] rs1_data_i,
  input  logic        is_ecall_i,
  input  logic        is_mret_i,
  input  logic [63:0] pc_i,
  output logic [1:0]  csr_state_o,
  output logic [11:0] csr_r_addr_o,
  output logic        csr_ren_o,
  output logic [11:0] csr_w_addr_o,
  output logic        csr_wen_o,
  output logic [63:0] csr_w_data_o,
  output logic [63:0] csr_pc_o,
  input  logic [63:0] csr_r_data_i,
  input  logic [63:0] csr_dnpc_i,
  output logic        rd_wen_o,
  output logic [63:0] rd_data_o,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o
);

  csr_fsm_e    state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [11:0] addr_q, addr_d;
  logic [4:0]  rs1_idx_q, rs1_idx_d;
  logic [63:0] rs1_data_q, rs1_data_d;
  logic [63:0] pc_q, pc_d;
  logic        trap_mret_q, trap_mret_d;
  logic [63:0] old_q, old_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;

  logic        accept;
  logic [63:0] alu_wdata;
  logic        alu_wen;

  assign in_ready_o = rst_n & (state_q == ST_IDLE) & ~redirect_valid_q;
  assign accept     = in_valid_i & in_ready_o;

  csr_wdata_alu u_alu (
    .funct3_i   (funct3_q),
    .rs1_idx_i  (rs1_idx_q),
    .rs1_data_i (rs1_data_q),
    .old_i      (old_q),
    .wdata_o    (alu_wdata),
    .wen_o      (alu_wen)
  );

  always_comb begin
    state_d          = state_q;
    funct3_d         = funct3_q;
    addr_d           = addr_q;
    rs1_idx_d        = rs1_idx_q;
    rs1_data_d       = rs1_data_q;
    pc_d             = pc_q;
    trap_mret_d      = trap_mret_q;
    old_d            = old_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          funct3_d   = funct3_i;
          addr_d     = csr_addr_i;
          rs1_idx_d  = rs1_idx_i;
          rs1_data_d = rs1_data_i;
          pc_d       = pc_i;
          if (is_ecall_i) begin
            trap_mret_d = 1'b0;
            state_d     = ST_TRAP;
          end else if (is_mret_i) begin
            trap_mret_d = 1'b1;
            state_d     = ST_TRAP;
          end else if (is_csr_op(funct3_i)) begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        old_d   = csr_r_data_i;
        state_d = ST_WR;
      end
      ST_WR: state_d = ST_IDLE;
      ST_TRAP: begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = csr_dnpc_i;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    csr_state_o      = CSR_STATE_IDLE;
    csr_r_addr_o     = '0;
    csr_ren_o        = 1'b0;
    csr_w_addr_o     = '0;
    csr_wen_o        = 1'b0;
    csr_w_data_o     = '0;
    csr_pc_o         = '0;
    rd_wen_o         = 1'b0;
    rd_data_o        = '0;
    redirect_valid_o = rst_n & redirect_valid_q;
    redirect_pc_o    = (rst_n & redirect_valid_q) ? redirect_pc_q : '0;
    if (rst_n) begin
      case (state_q)
        ST_RD: begin
          csr_ren_o    = 1'b1;
          csr_r_addr_o = addr_q;
        end
        ST_WR: begin
          rd_wen_o  = 1'b1;
          rd_data_o = old_q;
          if (alu_wen) begin
            csr_state_o  = CSR_STATE_RW;
            csr_wen_o    = 1'b1;
            csr_w_addr_o = addr_q;
            csr_w_data_o = alu_wdata;
          end
        end
        ST_TRAP: begin
          csr_state_o = trap_mret_q ? CSR_STATE_MRET : CSR_STATE_ECALL;
          csr_pc_o    = pc_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      funct3_q         <= '0;
      addr_q           <= '0;
      rs1_idx_q        <= '0;
      rs1_data_q       <= '0;
      pc_q             <= '0;
      trap_mret_q      <= 1'b0;
      old_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      funct3_q         <= funct3_d;
      addr_q           <= addr_d;
      rs1_idx_q        <= rs1_idx_d;
      rs1_data_q       <= rs1_data_d;
      pc_q             <= pc_d;
      trap_mret_q      <= trap_mret_d;
      old_q            <= old_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

endmodule

// File: tb/tb_csr_ctrl.sv
module tb_csr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_i, in_ready_o;
  logic [2:0]  funct3_i;
  logic [11:0] csr_addr_i;
  logic [4:0]  rs1_idx_i;
  logic [63:0] rs1_data_i;
  logic        is_ecall_i, is_mret_i;
  logic [63:0] pc_i;
  logic [1:0]  csr_state_o;
  logic [11:0] csr_r_addr_o, csr_w_addr_o;
  logic        csr_ren_o, csr_wen_o;
  logic [63:0] csr_w_data_o, csr_pc_o;
  logic [63:0] csr_r_data_i, csr_dnpc_i;
  logic        rd_wen_o;
  logic [63:0] rd_data_o;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;

  always #5 clk = ~clk;

  csr_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .funct3_i         (funct3_i),
    .csr_addr_i       (csr_addr_i),
    .rs1_idx_i        (rs1_idx_i),
    .rs1_data_i       (rs1_data_i),
    .is_ecall_i       (is_ecall_i),
    .is_mret_i        (is_mret_i),
    .pc_i             (pc_i),
    .csr_state_o      (csr_state_o),
    .csr_r_addr_o     (csr_r_addr_o),
    .csr_ren_o        (csr_ren_o),
    .csr_w_addr_o     (csr_w_addr_o),
    .csr_wen_o        (csr_wen_o),
    .csr_w_data_o     (csr_w_data_o),
    .csr_pc_o         (csr_pc_o),
    .csr_r_data_i     (csr_r_data_i),
    .csr_dnpc_i       (csr_dnpc_i),
    .rd_wen_o         (rd_wen_o),
    .rd_data_o        (rd_data_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o)
  );

  // Expected outputs for one cycle.
  typedef struct packed {
    logic        in_ready;
    logic [1:0]  st;
    logic        ren;
    logic [11:0] raddr;
    logic        wen;
    logic [11:0] waddr;
    logic [63:0] wdata;
    logic [63:0] pc;
    logic        rd_wen;
    logic [63:0] rd_data;
    logic        rv;
    logic [63:0] rpc;
  } exp_t;

  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

  exp_t pend[$];
  int   checks = 0;
  int   errors = 0;
  bit   started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: an accepted instruction schedules the outputs of the next two
  // cycles, computed straight from the CSR semantics; an empty schedule means
  // the block is idle and ready. Reset drops whatever was scheduled.
  always @(negedge clk) begin
    exp_t        e, a, b;
    logic [63:0] src, nv;
    if (started) begin
      e = '0;
      if (!rst_n) pend.delete();
      else if (pend.size() > 0) e = pend.pop_front();
      else e.in_ready = 1'b1;

      chk("in_ready", 64'(in_ready_o), 64'(e.in_ready));
      chk("csr_state", 64'(csr_state_o), 64'(e.st));
      chk("csr_ren", 64'(csr_ren_o), 64'(e.ren));
      chk("csr_r_addr", 64'(csr_r_addr_o), 64'(e.raddr));
      chk("csr_wen", 64'(csr_wen_o), 64'(e.wen));
      chk("csr_w_addr", 64'(csr_w_addr_o), 64'(e.waddr));
      chk("csr_w_data", csr_w_data_o, e.wdata);
      chk("csr_pc", csr_pc_o, e.pc);
      chk("rd_wen", 64'(rd_wen_o), 64'(e.rd_wen));
      chk("rd_data", rd_data_o, e.rd_data);
      chk("redirect_valid", 64'(redirect_valid_o), 64'(e.rv));
      chk("redirect_pc", redirect_pc_o, e.rpc);

      if (rst_n && e.in_ready && in_valid_i) begin
        a = '0;
        b = '0;
        if (is_ecall_i || is_mret_i) begin
          a.st  = is_ecall_i ? 2'd2 : 2'd3;
          a.pc  = pc_i;
          b.rv  = 1'b1;
          b.rpc = csr_dnpc_i;
          pend.push_back(a);
          pend.push_back(b);
        end else if (funct3_i == 3'd1 || funct3_i == 3'd2 || funct3_i == 3'd3 ||
                     funct3_i == 3'd5 || funct3_i == 3'd6 || funct3_i == 3'd7) begin
          src = (funct3_i >= 3'd5) ? 64'(rs1_idx_i) : rs1_data_i;
          if (funct3_i == 3'd1 || funct3_i == 3'd5) nv = src;
          else if (funct3_i == 3'd2 || funct3_i == 3'd6) nv = csr_r_data_i | src;
          else nv = csr_r_data_i & ~src;
          a.ren     = 1'b1;
          a.raddr   = csr_addr_i;
          b.rd_wen  = 1'b1;
          b.rd_data = csr_r_data_i;
          if (funct3_i == 3'd1 || funct3_i == 3'd5 || rs1_idx_i != 5'd0) begin
            b.st    = 2'd1;
            b.wen   = 1'b1;
            b.waddr = csr_addr_i;
            b.wdata = nv;
          end
          pend.push_back(a);
          pend.push_back(b);
        end
      end
    end
  end

  // Advance to just after the next rising edge; CSR-file inputs go to junk
  // so that only values captured at the right time can reach the outputs.
  task automatic step();
    @(posedge clk);
    #1;
    csr_r_data_i = JUNK;
    csr_dnpc_i   = JUNK;
  endtask

  // Present one instruction for one cycle (called just after a rising edge
  // of an idle cycle); returns just after the accepting edge.
  task automatic issue(input logic ecall, input logic mret, input logic [2:0] f3,
                       input logic [11:0] addr, input logic [4:0] idx,
                       input logic [63:0] data, input logic [63:0] pc,
                       input logic [63:0] old, input logic [63:0] dnpc);
    is_ecall_i   = ecall;
    is_mret_i    = mret;
    funct3_i     = f3;
    csr_addr_i   = addr;
    rs1_idx_i    = idx;
    rs1_data_i   = data;
    pc_i         = pc;
    csr_r_data_i = old;
    csr_dnpc_i   = dnpc;
    in_valid_i   = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    is_ecall_i = 1'b0;
    is_mret_i  = 1'b0;
  endtask

  typedef struct packed {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  idx;
    logic [63:0] data;
    logic [63:0] old;
  } vec_t;

  vec_t vecs[6];

  initial begin
    in_valid_i   = 1'b0;
    is_ecall_i   = 1'b0;
    is_mret_i    = 1'b0;
    funct3_i     = '0;
    csr_addr_i   = '0;
    rs1_idx_i    = '0;
    rs1_data_i   = '0;
    pc_i         = '0;
    csr_r_data_i = '0;
    csr_dnpc_i   = '0;
    started      = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("lit_reset_ready", 64'(in_ready_o), 64'd1);
    chk("lit_reset_state", 64'(csr_state_o), 64'd0);
    step();

    // CSRRW mtvec
    issue(0, 0, 3'b001, 12'h305, 5'd5, 64'h8000_0000, 64'h0, 64'h0, 64'h0);
    @(negedge clk);
    chk("lit_rw_ren", 64'(csr_ren_o), 64'd1);
    chk("lit_rw_raddr", 64'(csr_r_addr_o), 64'h305);
    step();
    @(negedge clk);
    chk("lit_rw_wen", 64'(csr_wen_o), 64'd1);
    chk("lit_rw_wdata", csr_w_data_o, 64'h8000_0000);
    chk("lit_rw_rd_data", rd_data_o, 64'h0);
    chk("lit_rw_state", 64'(csr_state_o), 64'd1);
    step();

    // CSRRS mstatus, then the same with rs1=x0
    issue(0, 0, 3'b010, 12'h300, 5'd3, 64'h8, 64'h0, 64'h1800, 64'h0);
    step();
    @(negedge clk);
    chk("lit_rs_wdata", csr_w_data_o, 64'h1808);
    step();
    issue(0, 0, 3'b010, 12'h300, 5'd0, 64'h8, 64'h0, 64'h1800, 64'h0);
    step();
    @(negedge clk);
    chk("lit_rs0_wen", 64'(csr_wen_o), 64'd0);
    chk("lit_rs0_rd_wen", 64'(rd_wen_o), 64'd1);
    chk("lit_rs0_rd_data", rd_data_o, 64'h1800);
    chk("lit_rs0_state", 64'(csr_state_o), 64'd0);
    step();

    // CSRRCI zimm 8
    issue(0, 0, 3'b111, 12'h300, 5'd8, 64'hFFFF, 64'h0, 64'h1888, 64'h0);
    step();
    @(negedge clk);
    chk("lit_rci_wdata", csr_w_data_o, 64'h1880);
    step();

    // ECALL
    issue(1, 0, 3'b000, 12'h0, 5'd0, 64'h0, 64'h8000_0100, 64'h0, 64'h8000_0400);
    @(negedge clk);
    chk("lit_ecall_state", 64'(csr_state_o), 64'd2);
    chk("lit_ecall_pc", csr_pc_o, 64'h8000_0100);
    step();
    @(negedge clk);
    chk("lit_redirect_valid", 64'(redirect_valid_o), 64'd1);
    chk("lit_redirect_pc", redirect_pc_o, 64'h8000_0400);
    chk("lit_redirect_ready", 64'(in_ready_o), 64'd0);
    step();
    @(negedge clk);
    chk("lit_after_redirect", 64'(redirect_valid_o), 64'd0);
    step();

    // ECALL and MRET together, then MRET alone
    issue(1, 1, 3'b000, 12'h0, 5'd0, 64'h0, 64'h8000_0200, 64'h0, 64'h8000_0500);
    @(negedge clk);
    chk("lit_prio_state", 64'(csr_state_o), 64'd2);
    step();
    step();
    issue(0, 1, 3'b000, 12'h0, 5'd0, 64'h0, 64'h8000_0300, 64'h0, 64'h8000_0600);
    @(negedge clk);
    chk("lit_mret_state", 64'(csr_state_o), 64'd3);
    step();
    step();

    // Non-CSR funct3: stays idle
    issue(0, 0, 3'b000, 12'h300, 5'd1, 64'h1, 64'h0, 64'h5, 64'h0);
    @(negedge clk);
    chk("lit_f3_000_ren", 64'(csr_ren_o), 64'd0);
    step();
    issue(0, 0, 3'b100, 12'h300, 5'd1, 64'h1, 64'h0, 64'h5, 64'h0);
    @(negedge clk);
    chk("lit_f3_100_ready", 64'(in_ready_o), 64'd1);
    step();

    // Valid while busy is dropped, not buffered
    issue(0, 0, 3'b001, 12'h341, 5'd1, 64'h55, 64'h0, 64'h7, 64'h0);
    step();
    funct3_i   = 3'b010;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    @(negedge clk);
    chk("lit_no_buffer_ren", 64'(csr_ren_o), 64'd0);
    step();
    issue(1, 0, 3'b000, 12'h0, 5'd0, 64'h0, 64'h8000_0700, 64'h0, 64'h8000_0800);
    step();
    is_mret_i  = 1'b1;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    is_mret_i  = 1'b0;
    @(negedge clk);
    chk("lit_no_buffer_trap", 64'(csr_state_o), 64'd0);
    step();

    // Reset during WR, TRAP and RD
    issue(0, 0, 3'b001, 12'h342, 5'd2, 64'h99, 64'h0, 64'h1, 64'h0);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("lit_rst_wr_wen", 64'(csr_wen_o), 64'd0);
    chk("lit_rst_wr_rd_wen", 64'(rd_wen_o), 64'd0);
    chk("lit_rst_wr_state", 64'(csr_state_o), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit_rst_wr_after", 64'(csr_wen_o), 64'd0);
    chk("lit_rst_wr_ready", 64'(in_ready_o), 64'd1);
    step();
    issue(1, 0, 3'b000, 12'h0, 5'd0, 64'h0, 64'h8000_0900, 64'h0, 64'h8000_0A00);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit_rst_trap_redirect", 64'(redirect_valid_o), 64'd0);
    step();
    issue(0, 0, 3'b001, 12'h305, 5'd4, 64'h1234, 64'h0, 64'h2, 64'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit_rst_rd_wen", 64'(csr_wen_o), 64'd0);
    chk("lit_rst_rd_rd_wen", 64'(rd_wen_o), 64'd0);
    step();

    // More operation patterns, checked by the model only
    vecs[0] = '{f3: 3'b101, addr: 12'h341, idx: 5'd17, data: 64'hFFFF_FFFF, old: 64'hAAAA};
    vecs[1] = '{f3: 3'b110, addr: 12'h300, idx: 5'd31, data: 64'h0, old: 64'h8000_0000_0000_0100};
    vecs[2] = '{f3: 3'b011, addr: 12'h342, idx: 5'd9, data: 64'hFF00_FF00_FF00_FF00, old: 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3] = '{f3: 3'b011, addr: 12'h342, idx: 5'd0, data: 64'hFF, old: 64'h1234};
    vecs[4] = '{f3: 3'b101, addr: 12'h305, idx: 5'd0, data: 64'h77, old: 64'h5555};
    vecs[5] = '{f3: 3'b001, addr: 12'h300, idx: 5'd0, data: 64'hCAFE_F00D_1234_5678, old: 64'h9};
    for (int i = 0; i < 6; i++) begin
      issue(0, 0, vecs[i].f3, vecs[i].addr, vecs[i].idx, vecs[i].data, 64'h0, vecs[i].old, 64'h0);
      step();
      step();
    end

    // Sustained valid: accepts every third cycle
    funct3_i     = 3'b010;
    csr_addr_i   = 12'h300;
    rs1_idx_i    = 5'd6;
    rs1_data_i   = 64'h40;
    csr_r_data_i = 64'h3;
    in_valid_i   = 1'b1;
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    in_valid_i = 1'b0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
